controller_reader: RTL and testbench
====================================

CONTROLLER_READER -- requirements
Module: controller_reader_m

Interface
REQ-001 SHALL have parameter BIT_CYCLES, default 12, meaning clk cycles per latch period and per bit period; legal range 4..255.
REQ-002 SHALL have port clk  input  1  system clock; all logic on posedge clk.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port poll_req  input  1  request one controller read frame; sampled only in IDLE.
REQ-005 SHALL have port data_B_1  input  1  controller 1 serial data, active-low, asynchronous to clk.
REQ-006 SHALL have port data_B_2  input  1  controller 2 serial data, active-low, asynchronous to clk.
REQ-007 SHALL have port latch  output  1  shared latch to both controllers.
REQ-008 SHALL have port ctrl_clk_enable  output  1  shared single-cycle shift/load strobe to both controllers' clk_in_enable.
REQ-009 SHALL have port buttons_1  output  8  controller 1 state, active-high, {a,b,select,start,up,down,left,right}.
REQ-010 SHALL have port buttons_2  output  8  controller 2 state, same format.
REQ-011 SHALL have port valid  output  1  one-cycle pulse: buttons_1/buttons_2 were just updated.
REQ-012 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-013 SHALL pass each data_B_n through a 2-flop synchronizer before use; sampling uses the second flop only.
REQ-014 SHALL implement states IDLE, LATCH, BIT, DONE with a bit index 0..7 and a cycle counter 0..BIT_CYCLES-1.
REQ-015 IDLE: latch=0, ctrl_clk_enable=0; poll_req=1 at an edge -> LATCH at that edge, counter=0.
REQ-016 LATCH: latch=1 for exactly BIT_CYCLES cycles; ctrl_clk_enable=1 in the final LATCH cycle only (sync-latch controllers load there); then BIT with index 0.
REQ-017 BIT: latch=0; each bit lasts BIT_CYCLES cycles; in the final cycle of each bit, shift {sr[6:0], ~synced data_B_n} into per-controller shift registers and assert ctrl_clk_enable for that cycle.
REQ-018 After the final cycle of bit 7 SHALL enter DONE; buttons_1/buttons_2 load from the shift registers at that edge; the first serial bit lands in bit 7 (a).
REQ-019 DONE: valid=1 for exactly one cycle; return to IDLE next edge; buttons hold until the next DONE or reset.
REQ-020 Timing, poll_req accepted at edge E0: latch high cycles 1..B; bit k occupies cycles B(k+1)+1..B(k+2); valid in cycle 9B+1; IDLE from cycle 9B+2 (B=BIT_CYCLES).
REQ-021 poll_req while busy SHALL be ignored, not queued; poll_req held high yields back-to-back frames, one every 9B+2 cycles.
REQ-022 ctrl_clk_enable SHALL pulse exactly 9 times per frame (1 load + 8 shift); shifting past bit 7 is harmless.
REQ-023 Disconnected controller (data_B pulled high) SHALL read 8'h00; no presence detection.
REQ-024 Buttons SHALL reflect state captured at latch; input changes after the latch cycle do not affect the frame.

Reset
REQ-025 rst=1 at an edge SHALL force IDLE, counters 0, shift registers 0, synchronizer flops 1, latch=0, ctrl_clk_enable=0, valid=0, busy=0, buttons_1=buttons_2=8'h00.
REQ-026 rst mid-frame SHALL abort the frame without valid; rst has priority over poll_req in the same cycle.

Verification
REQ-027 Reset then idle 50 cycles -> all outputs 0, no ctrl_clk_enable pulses.
REQ-028 B=4, sync-latch controller model, buttons_B_1=8'b0111_1110, poll_req one cycle -> latch cycles 1..4, 9 strobes, valid in cycle 37, buttons_1=8'h81.
REQ-029 B=4, transparent-latch controller model on port 2 with buttons_B=8'hFF, port 1 with 8'h00 -> buttons_2=8'h00, buttons_1=8'hFF, single valid pulse.
REQ-030 poll_req held high 200 cycles -> valid every 38 cycles, busy low exactly 1 cycle between frames.
REQ-031 rst asserted in cycle 15 of a frame -> next cycle latch=0, busy=0, buttons=0, no valid; subsequent poll completes normally.
REQ-032 Model buttons change from 8'hFF to 8'h00 in cycle 10 of a frame -> buttons read 8'h00 (latched value), not a mix.

Source files
------------

// File: rtl/controller_reader.sv
// Reads two serial game controllers: latches both, shifts eight bits out of each
// and presents the decoded active-high button state with a one-cycle valid pulse.
module controller_reader #(
  parameter int unsigned BIT_CYCLES = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       poll_req,
  input  logic       data_B_1,
  input  logic       data_B_2,
  output logic       latch,
  output logic       ctrl_clk_enable,
  output logic [7:0] buttons_1,
  output logic [7:0] buttons_2,
  output logic       valid,
  output logic       busy
);

  localparam logic [7:0] CntLast = 8'(BIT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StLatch, StBit, StDone} state_e;

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] sr1_q, sr1_d;
  logic [7:0] sr2_q, sr2_d;
  logic [7:0] btn1_q, btn1_d;
  logic [7:0] btn2_q, btn2_d;
  logic [1:0] sync1_q, sync1_d;
  logic [1:0] sync2_q, sync2_d;
  logic       cnt_last;
  logic [7:0] sr1_shift, sr2_shift;

  assign sync1_d   = {sync1_q[0], data_B_1};
  assign sync2_d   = {sync2_q[0], data_B_2};
  assign cnt_last  = (cnt_q == CntLast);
  // Serial data is active-low; invert on the way into the shift registers.
  assign sr1_shift = {sr1_q[6:0], ~sync1_q[1]};
  assign sr2_shift = {sr2_q[6:0], ~sync2_q[1]};

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    idx_d           = idx_q;
    sr1_d           = sr1_q;
    sr2_d           = sr2_q;
    btn1_d          = btn1_q;
    btn2_d          = btn2_q;
    latch           = 1'b0;
    ctrl_clk_enable = 1'b0;
    valid           = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (poll_req) begin
          state_d = StLatch;
          cnt_d   = 8'd0;
        end
      end
      StLatch: begin
        latch = 1'b1;
        if (cnt_last) begin
          // Sync-latch controllers load their shift registers on this strobe.
          ctrl_clk_enable = 1'b1;
          state_d         = StBit;
          cnt_d           = 8'd0;
          idx_d           = 3'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StBit: begin
        if (cnt_last) begin
          ctrl_clk_enable = 1'b1;
          sr1_d           = sr1_shift;
          sr2_d           = sr2_shift;
          cnt_d           = 8'd0;
          if (idx_q == 3'd7) begin
            state_d = StDone;
            btn1_d  = sr1_shift;
            btn2_d  = sr2_shift;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StDone: begin
        valid   = 1'b1;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 8'd0;
      idx_q   <= 3'd0;
      sr1_q   <= 8'd0;
      sr2_q   <= 8'd0;
      btn1_q  <= 8'd0;
      btn2_q  <= 8'd0;
      sync1_q <= 2'b11;
      sync2_q <= 2'b11;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sr1_q   <= sr1_d;
      sr2_q   <= sr2_d;
      btn1_q  <= btn1_d;
      btn2_q  <= btn2_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign buttons_1 = btn1_q;
  assign buttons_2 = btn2_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_controller_reader.sv
// Randomized self-checking bench for controller_reader with behavioural
// sync-latch / transparent-latch controller models on both ports.
module tb_controller_reader;

  localparam int B     = 4;
  localparam int Frame = 9 * B + 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       poll_req;
  logic       data_b_1, data_b_2;
  logic       latch, ctrl_clk_enable, valid, busy;
  logic [7:0] buttons_1, buttons_2;

  // Controller models: bb = active-low buttons, sr = controller shift register.
  logic [7:0] bb1, bb2, sr1, sr2;
  logic       mode1, mode2;  // 1 = transparent latch, 0 = sync latch
  logic       conn1, conn2;

  int n_checks = 0;
  int n_errors = 0;

  controller_reader #(.BIT_CYCLES(B)) u_dut (
    .clk             (clk),
    .rst             (rst),
    .poll_req        (poll_req),
    .data_B_1        (data_b_1),
    .data_B_2        (data_b_2),
    .latch           (latch),
    .ctrl_clk_enable (ctrl_clk_enable),
    .buttons_1       (buttons_1),
    .buttons_2       (buttons_2),
    .valid           (valid),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  assign data_b_1 = !conn1 ? 1'b1 : (mode1 && latch) ? bb1[7] : sr1[7];
  assign data_b_2 = !conn2 ? 1'b1 : (mode2 && latch) ? bb2[7] : sr2[7];

  always @(posedge clk) begin
    if (latch && (mode1 || ctrl_clk_enable)) sr1 <= bb1;
    else if (ctrl_clk_enable)                sr1 <= {sr1[6:0], 1'b1};
    if (latch && (mode2 || ctrl_clk_enable)) sr2 <= bb2;
    else if (ctrl_clk_enable)                sr2 <= {sr2[6:0], 1'b1};
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full frame from a poll; chg_cyc != 0 swaps the model buttons in that cycle.
  task automatic run_frame(input logic [7:0] e1, input logic [7:0] e2, input int chg_cyc,
                           input logic [7:0] n1, input logic [7:0] n2);
    int lat_cnt = 0, lat_first = 0, lat_last = 0, strobes = 0;
    int vcnt = 0, vcyc = 0, busy_cnt = 0;
    logic busy_end = 1'b1;
    poll_req = 1'b1;
    tick();
    poll_req = 1'b0;
    for (int c = 1; c <= Frame; c++) begin
      if (latch) begin
        lat_cnt++;
        if (lat_first == 0) lat_first = c;
        lat_last = c;
      end
      if (ctrl_clk_enable) strobes++;
      if (valid) begin
        vcnt++;
        vcyc = c;
      end
      if (busy) busy_cnt++;
      if (c == Frame) busy_end = busy;
      if (c == chg_cyc) begin
        bb1 = n1;
        bb2 = n2;
      end
      if (c < Frame) tick();
    end
    check_eq("latch_cycles", lat_cnt, B);
    check_eq("latch_first", lat_first, 1);
    check_eq("latch_last", lat_last, B);
    check_eq("strobes", strobes, 9);
    check_eq("valid_count", vcnt, 1);
    check_eq("valid_cycle", vcyc, 9 * B + 1);
    check_eq("busy_cycles", busy_cnt, 9 * B + 1);
    check_eq("busy_after", busy_end, 1'b0);
    check_eq("buttons_1", buttons_1, e1);
    check_eq("buttons_2", buttons_2, e2);
  endtask

  initial begin
    int lat_n, cen_n, val_n, busy_n, last_v, low_run, v_total;
    logic [7:0] a1, a2;
    rst = 1'b1; poll_req = 1'b0;
    bb1 = 8'hFF; bb2 = 8'hFF; sr1 = 8'hFF; sr2 = 8'hFF;
    mode1 = 1'b0; mode2 = 1'b0; conn1 = 1'b0; conn2 = 1'b0;
    repeat (3) tick();
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_buttons_1", buttons_1, 8'h00);
    rst = 1'b0;

    // Idle after reset: nothing moves.
    lat_n = 0; cen_n = 0; val_n = 0; busy_n = 0;
    for (int c = 0; c < 50; c++) begin
      tick();
      lat_n += int'(latch); cen_n += int'(ctrl_clk_enable);
      val_n += int'(valid); busy_n += int'(busy);
    end
    check_eq("idle_latch", lat_n, 0);
    check_eq("idle_strobes", cen_n, 0);
    check_eq("idle_valid", val_n, 0);
    check_eq("idle_busy", busy_n, 0);
    check_eq("idle_buttons_1", buttons_1, 8'h00);
    check_eq("idle_buttons_2", buttons_2, 8'h00);

    // Sync-latch controller on port 1, port 2 disconnected.
    conn1 = 1'b1; mode1 = 1'b0; bb1 = 8'b0111_1110;
    run_frame(8'h81, 8'h00, 0, 8'h00, 8'h00);

    // Transparent-latch controllers, nothing pressed on 2, everything on 1.
    conn1 = 1'b1; conn2 = 1'b1; mode1 = 1'b1; mode2 = 1'b1;
    bb1 = 8'h00; bb2 = 8'hFF;
    run_frame(8'hFF, 8'h00, 0, 8'h00, 8'h00);

    // Inputs change after the latch: captured value wins.
    mode1 = 1'b0; mode2 = 1'b1; bb1 = 8'hFF; bb2 = 8'hFF;
    run_frame(8'h00, 8'h00, 10, 8'h00, 8'h00);

    // Randomized frames.
    for (int i = 0; i < 12; i++) begin
      conn1 = 1'($urandom); conn2 = 1'($urandom);
      mode1 = 1'($urandom); mode2 = 1'($urandom);
      a1 = 8'($urandom); a2 = 8'($urandom);
      bb1 = a1; bb2 = a2;
      run_frame(conn1 ? ~a1 : 8'h00, conn2 ? ~a2 : 8'h00,
                int'($urandom_range(B + 1, 9 * B)), 8'($urandom), 8'($urandom));
    end

    // poll_req held high: back-to-back frames.
    conn1 = 1'b1; conn2 = 1'b1; bb1 = 8'h3C; bb2 = 8'hC3;
    poll_req = 1'b1;
    last_v = 0; low_run = 0; v_total = 0;
    for (int c = 1; c <= 200; c++) begin
      tick();
      if (valid) begin
        v_total++;
        if (last_v > 0) check_eq("valid_period", c - last_v, Frame);
        last_v = c;
      end
      if (!busy) low_run++;
      else begin
        if (low_run > 0) check_eq("busy_gap", low_run, 1);
        low_run = 0;
      end
    end
    check_eq("held_valid_count", v_total, 5);
    poll_req = 1'b0;
    repeat (Frame) tick();
    check_eq("held_buttons_1", buttons_1, 8'hC3);
    check_eq("held_buttons_2", buttons_2, 8'h3C);

    // Reset in cycle 15 of a frame aborts it.
    poll_req = 1'b1;
    tick();
    poll_req = 1'b0;
    for (int c = 2; c <= 15; c++) tick();
    rst = 1'b1;
    tick();
    check_eq("abort_latch", latch, 1'b0);
    check_eq("abort_busy", busy, 1'b0);
    check_eq("abort_buttons_1", buttons_1, 8'h00);
    check_eq("abort_buttons_2", buttons_2, 8'h00);
    rst = 1'b0;
    val_n = 0;
    for (int c = 0; c < 50; c++) begin
      tick();
      val_n += int'(valid);
    end
    check_eq("abort_no_valid", val_n, 0);

    // Reset wins over a simultaneous poll.
    rst = 1'b1; poll_req = 1'b1;
    tick();
    rst = 1'b0; poll_req = 1'b0;
    check_eq("rst_priority_busy", busy, 1'b0);
    tick();
    check_eq("rst_priority_idle", busy, 1'b0);

    mode1 = 1'b0; mode2 = 1'b0; bb1 = 8'h5A; bb2 = 8'hE1;
    run_frame(8'hA5, 8'h1E, 0, 8'h00, 8'h00);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
